instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, setting the instruction, address and PC width.
REQ-002 The module SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-003 The module SHALL have parameter FIFO_DEPTH, default 2, the instruction buffer depth (power of 2, ≥2).
REQ-004 Port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port o_imem_req_valid, output, 1 bit: fetch request valid.
REQ-007 Port i_imem_req_ready, input, 1 bit: memory accepts the request.
REQ-008 Port o_imem_req_addr, output, DATA_WIDTH: fetch address.
REQ-009 Port i_imem_rsp_valid, input, 1 bit: response valid; responses arrive in request order with no backpressure.
REQ-010 Port i_imem_rsp_data, input, DATA_WIDTH: fetched instruction word.
REQ-011 Port o_instr_valid, output, 1 bit: instruction available to decode.
REQ-012 Port i_instr_ready, input, 1 bit: decode consumes the instruction.
REQ-013 Port o_instr, output, DATA_WIDTH: instruction at the buffer head.
REQ-014 Port o_instr_pc, output, DATA_WIDTH: PC of o_instr.
REQ-015 Port i_redirect_valid, input, 1 bit: branch/jump redirect, one-cycle pulse.
REQ-016 Port i_redirect_pc, input, DATA_WIDTH: redirect target.

Function
REQ-017 A request handshake SHALL occur when o_imem_req_valid and i_imem_req_ready are both high; each handshake increments the fetch PC by 4 (modulo 2^DATA_WIDTH) and increments the outstanding count.
REQ-018 o_imem_req_valid SHALL be high only in FETCH and only when registered (outstanding + fifo_count) < FIFO_DEPTH; a same-cycle pop SHALL NOT free a credit until the next cycle.
REQ-019 o_imem_req_addr and o_imem_req_valid SHALL hold stable while valid is high and ready is low.
REQ-020 Each response SHALL decrement outstanding; if the discard count is nonzero, the response SHALL be dropped and the discard count decremented; otherwise {data, PC} SHALL be pushed to the FIFO.
REQ-021 The PC stored with each instruction SHALL be the address of its request, tracked by a FIFO-depth PC queue.
REQ-022 A response while outstanding is 0 SHALL be ignored.
REQ-023 The FIFO output SHALL be registered: a response in cycle N into an empty FIFO SHALL appear on o_instr_valid in cycle N+1.
REQ-024 A pop SHALL occur on o_instr_valid && i_instr_ready; a push and a pop in the same cycle SHALL leave fifo_count unchanged.
REQ-025 On i_redirect_valid: the FIFO SHALL be flushed (o_instr_valid low the next cycle); the discard count SHALL be set to outstanding after this cycle's handshakes; the fetch PC SHALL load i_redirect_pc.
REQ-026 A response and a request handshake in the redirect cycle SHALL both be treated as stale; the first request to i_redirect_pc SHALL be issued no earlier than the cycle after the redirect.
REQ-027 A pop in the redirect cycle SHALL complete normally.
REQ-028 The state machine SHALL have states IDLE (entered on reset, lasts one cycle), then FETCH, and, when REQ-033 is enabled, HALT.

Reset
REQ-029 While i_reset is high: state=IDLE, fetch PC=RESET_PC, outstanding=0, discard=0, fifo_count=0, o_imem_req_valid=0, o_instr_valid=0, o_instr=0, o_instr_pc=0.
REQ-030 The first request SHALL be issued with address RESET_PC in the second cycle after i_reset falls.
REQ-031 Reset asserted with requests outstanding SHALL discard all pending state; responses arriving after reset to pre-reset requests are the memory's responsibility (it is reset on the same signal).

Configuration
REQ-032 Macro IFU_MISALIGN_CHECK_EN SHALL select misaligned-redirect handling.
REQ-033 With IFU_MISALIGN_CHECK_EN defined: a redirect with i_redirect_pc[1:0]!=0 SHALL enter HALT, add output o_fetch_misaligned (1 bit, reset 0) driven high in HALT, and issue no requests; the next aligned redirect SHALL return to FETCH and clear it.
REQ-034 Without IFU_MISALIGN_CHECK_EN: the port SHALL NOT exist, and i_redirect_pc[1:0] SHALL be treated as 00.

Verification
REQ-035 Release reset, ready=1, 1-cycle memory -> requests at 0x0, 0x4, 0x8...; instructions delivered in order with matching o_instr_pc.
REQ-036 Hold i_instr_ready=0 -> at most FIFO_DEPTH requests issued, FIFO fills to 2, req_valid stays low; raise ready -> fetching resumes, no loss or duplication.
REQ-037 Two outstanding, redirect to 0x100 -> both old responses dropped, next delivered instruction has o_instr_pc=0x100.
REQ-038 Redirect in the same cycle as a response and a pop -> popped instruction consumed, response dropped, FIFO empty next cycle.
REQ-039 i_imem_req_ready=0 for 5 cycles -> address and valid held constant throughout.
REQ-040 With IFU_MISALIGN_CHECK_EN, redirect to 0x102 -> o_fetch_misaligned=1, no requests; redirect to 0x200 -> flag clears and fetching resumes at 0x200.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: credit-limited sequential fetch, in-order response buffering, redirect flush.
// Optional build macro IFU_MISALIGN_CHECK_EN adds a HALT state and o_fetch_misaligned for misaligned redirects.
module instr_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    output logic                  o_imem_req_valid,
    input  logic                  i_imem_req_ready,
    output logic [DATA_WIDTH-1:0] o_imem_req_addr,
    input  logic                  i_imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] i_imem_rsp_data,
    output logic                  o_instr_valid,
    input  logic                  i_instr_ready,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [DATA_WIDTH-1:0] o_instr_pc,
    input  logic                  i_redirect_valid,
    input  logic [DATA_WIDTH-1:0] i_redirect_pc
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    output logic                  o_fetch_misaligned
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH
`ifdef IFU_MISALIGN_CHECK_EN
        ,
        S_HALT
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]         outst_q, outst_d;
    logic [CW-1:0]         discard_q, discard_d;
    logic [CW-1:0]         count_q, count_d;
    logic [AW-1:0]         pcq_wr_q, pcq_rd_q;
    logic [AW-1:0]         fifo_wr_q, fifo_rd_q;

    logic [DATA_WIDTH-1:0] pcq_mem       [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_pc_mem   [FIFO_DEPTH];

    logic                  req_fire, rsp_fire, push, pop;
    logic [DATA_WIDTH-1:0] target_pc;

`ifdef IFU_MISALIGN_CHECK_EN
    logic target_misaligned;
    assign target_misaligned  = |i_redirect_pc[1:0];
    assign target_pc          = i_redirect_pc;
    assign o_fetch_misaligned = (state_q == S_HALT);
`else
    // Low address bits are forced to zero; they carry no information here.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^i_redirect_pc[1:0];
    assign target_pc           = {i_redirect_pc[DATA_WIDTH-1:2], 2'b00};
`endif

    assign req_fire = o_imem_req_valid & i_imem_req_ready;
    assign rsp_fire = i_imem_rsp_valid & (outst_q != '0);
    assign pop      = o_instr_valid & i_instr_ready;
    // A response landing in the redirect cycle belongs to the old stream.
    assign push     = rsp_fire & (discard_q == '0) & ~i_redirect_valid;

    always_comb begin
        state_d          = state_q;
        o_imem_req_valid = 1'b0;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: o_imem_req_valid = ({1'b0, outst_q} + {1'b0, count_q}) < DEPTH_C;
            default: state_d = state_q;
        endcase
`ifdef IFU_MISALIGN_CHECK_EN
        if (i_redirect_valid) begin
            state_d = target_misaligned ? S_HALT : S_FETCH;
        end
`endif
    end

    always_comb begin
        outst_d = outst_q + CW'(req_fire) - CW'(rsp_fire);
        if (i_redirect_valid) begin
            discard_d = outst_d;
        end else if (rsp_fire && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end else begin
            discard_d = discard_q;
        end
        if (i_redirect_valid) begin
            pc_d = target_pc;
        end else if (req_fire) begin
            pc_d = pc_q + DATA_WIDTH'(4);
        end else begin
            pc_d = pc_q;
        end
        count_d = i_redirect_valid ? '0 : (count_q + CW'(push) - CW'(pop));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            outst_q   <= '0;
            discard_q <= '0;
            count_q   <= '0;
            pcq_wr_q  <= '0;
            pcq_rd_q  <= '0;
            fifo_wr_q <= '0;
            fifo_rd_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            count_q   <= count_d;
            // The PC queue tracks in-flight requests, so it survives redirects.
            pcq_wr_q  <= pcq_wr_q + AW'(req_fire);
            pcq_rd_q  <= pcq_rd_q + AW'(rsp_fire);
            if (i_redirect_valid) begin
                fifo_wr_q <= '0;
                fifo_rd_q <= '0;
            end else begin
                fifo_wr_q <= fifo_wr_q + AW'(push);
                fifo_rd_q <= fifo_rd_q + AW'(pop);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (req_fire) begin
            pcq_mem[pcq_wr_q] <= pc_q;
        end
        if (push) begin
            fifo_data_mem[fifo_wr_q] <= i_imem_rsp_data;
            fifo_pc_mem[fifo_wr_q]   <= pcq_mem[pcq_rd_q];
        end
    end

    assign o_imem_req_addr = pc_q;
    assign o_instr_valid   = (count_q != '0);
    assign o_instr         = o_instr_valid ? fifo_data_mem[fifo_rd_q] : '0;
    assign o_instr_pc      = o_instr_valid ? fifo_pc_mem[fifo_rd_q]   : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit: in-order memory model plus a sequential
// program-stream reference; also exercises the IFU_MISALIGN_CHECK_EN build when that macro is defined.
module tb_instr_fetch_unit;
    localparam int          W      = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          i_reset, i_imem_req_ready, i_imem_rsp_valid, i_instr_ready, i_redirect_valid;
    logic [W-1:0]  i_imem_rsp_data, i_redirect_pc;
    logic          o_imem_req_valid, o_instr_valid;
    logic [W-1:0]  o_imem_req_addr, o_instr, o_instr_pc;
`ifdef IFU_MISALIGN_CHECK_EN
    logic          o_fetch_misaligned;
`endif

    instr_fetch_unit #(.DATA_WIDTH(W), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk            (clk),
        .i_reset          (i_reset),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_req_addr  (o_imem_req_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .o_instr_valid    (o_instr_valid),
        .i_instr_ready    (i_instr_ready),
        .o_instr          (o_instr),
        .o_instr_pc       (o_instr_pc),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc)
`ifdef IFU_MISALIGN_CHECK_EN
        ,
        .o_fetch_misaligned (o_fetch_misaligned)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Instruction memory contents as a pure function of address.
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

    mreq_t       mem_q[$];
    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] next_pc;
    bit          halted = 0;

    function automatic void topup();
        if (!halted) begin
            while (exp_q.size() < 4) begin
                exp_q.push_back('{next_pc, mem_data(next_pc)});
                next_pc = next_pc + 32'd4;
            end
        end
    endfunction

    function automatic void stream_restart(input logic [31:0] t);
        exp_q.delete();
        next_pc = t;
        topup();
    endfunction

    // Stimulus knobs
    int   cyc = 0;
    int   p_req_rdy = 100, p_instr_rdy = 100, p_redir = 0, p_spur = 0;
    int   lat_min = 1, lat_max = 1;
    bit   rst_drive = 1;
    bit   forced_redirect = 0;
    logic [31:0] forced_target = '0;
    bit   want_038 = 0;

    // Observation state
    int   n_pops = 0, n_hs = 0;
    logic [31:0] last_pop_pc = '0;
    int   rst_age = 0, since_rst = 0;
    bit   prev_stall = 0, prev_redirect = 0;
    logic [31:0] prev_addr = '0;

    always @(posedge clk) begin
        if (i_reset) begin
            rst_age   <= rst_age + 1;
            since_rst <= 0;
        end else begin
            rst_age <= 0;
            if (since_rst < 1000) since_rst <= since_rst + 1;
        end
    end

    task automatic drive_cycle();
        logic [31:0] t;
        @(negedge clk);
        cyc++;
        i_reset          = rst_drive;
        i_imem_req_ready = ($urandom_range(99) < p_req_rdy);
        i_instr_ready    = ($urandom_range(99) < p_instr_rdy);
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data  = $urandom;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = $urandom;
        if (!rst_drive) begin
            if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
                i_imem_rsp_valid = 1'b1;
                i_imem_rsp_data  = mem_data(mem_q[0].addr);
                void'(mem_q.pop_front());
            end else if (mem_q.size() == 0 && $urandom_range(99) < p_spur) begin
                i_imem_rsp_valid = 1'b1;
            end
`ifdef IFU_MISALIGN_CHECK_EN
            t = 32'($urandom_range(0, 255)) << 2;
`else
            t = 32'($urandom_range(0, 1023));
`endif
            if (forced_redirect) begin
                i_redirect_valid = 1'b1;
                i_redirect_pc    = forced_target;
                forced_redirect  = 0;
            end else if (want_038 && o_instr_valid && i_imem_rsp_valid) begin
                i_instr_ready    = 1'b1;
                i_redirect_valid = 1'b1;
                i_redirect_pc    = t;
                want_038         = 0;
            end else if ($urandom_range(999) < p_redir) begin
                i_redirect_valid = 1'b1;
                i_redirect_pc    = t;
            end
        end
    endtask

    // Monitor / scoreboard: observes each cycle's settled inputs and outputs.
    always @(negedge clk) begin
        #1;
        if (i_reset) begin
            mem_q.delete();
            halted = 0;
            stream_restart(RST_PC);
            prev_stall    = 0;
            prev_redirect = 0;
            if (rst_age >= 1) begin
                check("rst_req_valid", {31'd0, o_imem_req_valid}, 32'd0);
                check("rst_instr_valid", {31'd0, o_instr_valid}, 32'd0);
                check("rst_instr", o_instr, 32'd0);
                check("rst_instr_pc", o_instr_pc, 32'd0);
`ifdef IFU_MISALIGN_CHECK_EN
                check("rst_misaligned", {31'd0, o_fetch_misaligned}, 32'd0);
`endif
            end
        end else begin
            if (since_rst == 0) check("idle_no_req", {31'd0, o_imem_req_valid}, 32'd0);
            if (since_rst == 1) begin
                check("first_req_valid", {31'd0, o_imem_req_valid}, 32'd1);
                check("first_req_addr", o_imem_req_addr, RST_PC);
            end
            if (prev_stall) begin
                check("hold_valid", {31'd0, o_imem_req_valid}, 32'd1);
                check("hold_addr", o_imem_req_addr, prev_addr);
            end
            if (prev_redirect) check("flush_valid", {31'd0, o_instr_valid}, 32'd0);
`ifdef IFU_MISALIGN_CHECK_EN
            if (halted) begin
                check("halt_flag", {31'd0, o_fetch_misaligned}, 32'd1);
                check("halt_no_req", {31'd0, o_imem_req_valid}, 32'd0);
            end else if (since_rst >= 1) begin
                check("run_flag", {31'd0, o_fetch_misaligned}, 32'd0);
            end
`endif
            if (o_instr_valid && i_instr_ready) begin
                n_pops++;
                last_pop_pc = o_instr_pc;
                $display("[TB] cyc=%0d instr pc=0x%08h data=0x%08h", cyc, o_instr_pc, o_instr);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_instr: got pc 0x%08h required none", o_instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", o_instr_pc, e.pc);
                    check("instr_data", o_instr, e.data);
                    topup();
                end
            end
            if (o_imem_req_valid && i_imem_req_ready) begin
                n_hs++;
                mem_q.push_back('{o_imem_req_addr, cyc + $urandom_range(lat_min, lat_max)});
                check("credit", {31'd0, (mem_q.size() <= DEPTH)}, 32'd1);
            end
            if (i_redirect_valid) begin
`ifdef IFU_MISALIGN_CHECK_EN
                if (i_redirect_pc[1:0] != 2'b00) begin
                    halted = 1;
                    exp_q.delete();
                end else begin
                    halted = 0;
                    stream_restart(i_redirect_pc);
                end
`else
                stream_restart(i_redirect_pc & ~32'h3);
`endif
            end
            prev_stall    = o_imem_req_valid && !i_imem_req_ready && !i_redirect_valid;
            prev_addr     = o_imem_req_addr;
            prev_redirect = i_redirect_valid;
        end
    end

    task automatic do_reset();
        rst_drive = 1;
        repeat (3) drive_cycle();
        rst_drive = 0;
    endtask

    task automatic expect_next_pop_pc(input string name, input logic [31:0] pc);
        int  start;
        bit  got;
        start = n_pops;
        got   = 0;
        for (int i = 0; i < 60; i++) begin
            drive_cycle();
            #2;
            if (n_pops != start) begin
                got = 1;
                break;
            end
        end
        check({name, "_seen"}, {31'd0, got}, 32'd1);
        if (got) check(name, last_pop_pc, pc);
    endtask

    initial begin
        int  hs0;
        bit  found;
        logic [31:0] held;
        i_reset = 1'b1; i_imem_req_ready = 1'b0; i_imem_rsp_valid = 1'b0; i_instr_ready = 1'b0;
        i_redirect_valid = 1'b0; i_imem_rsp_data = '0; i_redirect_pc = '0;

        // Decode stalled: credits cap requests at FIFO_DEPTH, then resume in order.
        do_reset();
        p_instr_rdy = 0;
        hs0 = n_hs;
        repeat (10) begin drive_cycle(); #2; end
        check("stall_req_count", n_hs - hs0, DEPTH);
        check("stall_req_valid", {31'd0, o_imem_req_valid}, 32'd0);
        check("stall_instr_valid", {31'd0, o_instr_valid}, 32'd1);
        p_instr_rdy = 100;
        expect_next_pop_pc("resume_pc0", RST_PC);
        repeat (30) drive_cycle();

        // Redirect with two requests in flight.
        do_reset();
        lat_min = 3; lat_max = 3;
        found = 0;
        for (int i = 0; i < 30; i++) begin
            drive_cycle(); #2;
            if (mem_q.size() >= 2) begin found = 1; break; end
        end
        check("two_outstanding", {31'd0, found}, 32'd1);
        forced_target = 32'h100; forced_redirect = 1;
        drive_cycle(); #2;
        expect_next_pop_pc("redir_0x100", 32'h100);

        // Memory not ready: request held stable.
        lat_min = 1; lat_max = 1; p_req_rdy = 0;
        found = 0;
        for (int i = 0; i < 30; i++) begin
            drive_cycle(); #2;
            if (o_imem_req_valid) begin found = 1; break; end
        end
        check("hold_seen_valid", {31'd0, found}, 32'd1);
        held = o_imem_req_addr;
        repeat (5) begin
            drive_cycle(); #2;
            check("hold5_valid", {31'd0, o_imem_req_valid}, 32'd1);
            check("hold5_addr", o_imem_req_addr, held);
        end
        p_req_rdy = 100;

        // Redirect coinciding with a response and a pop.
        p_instr_rdy = 60; lat_max = 2; want_038 = 1;
        for (int i = 0; i < 200; i++) begin
            drive_cycle(); #2;
            if (!want_038) break;
        end
        check("redir_rsp_pop_hit", {31'd0, want_038}, 32'd0);
        drive_cycle(); #2;
        check("redir_rsp_pop_empty", {31'd0, o_instr_valid}, 32'd0);
        want_038 = 0; p_instr_rdy = 100;

`ifdef IFU_MISALIGN_CHECK_EN
        forced_target = 32'h102; forced_redirect = 1;
        drive_cycle(); #2;
        hs0 = n_hs;
        repeat (6) begin drive_cycle(); #2; end
        check("misalign_flag", {31'd0, o_fetch_misaligned}, 32'd1);
        check("misalign_no_req", n_hs - hs0, 0);
        forced_target = 32'h200; forced_redirect = 1;
        drive_cycle(); #2;
        drive_cycle(); #2;
        check("misalign_cleared", {31'd0, o_fetch_misaligned}, 32'd0);
        expect_next_pop_pc("resume_0x200", 32'h200);
`else
        forced_target = 32'h102; forced_redirect = 1;
        drive_cycle(); #2;
        expect_next_pop_pc("misalign_ignored", 32'h100);
`endif

        // Randomized traffic with redirects, spurious responses and a mid-run reset.
        for (int blk = 0; blk < 6; blk++) begin
            p_req_rdy   = $urandom_range(30, 100);
            p_instr_rdy = $urandom_range(20, 100);
            lat_min     = 1;
            lat_max     = $urandom_range(1, 4);
            p_redir     = $urandom_range(0, 60);
            p_spur      = $urandom_range(0, 30);
            if (blk == 3) do_reset();
            repeat (250) drive_cycle();
        end
        #2;
        check("progress", {31'd0, (n_pops >= 150)}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
